t_mux_scan_ctrl: RTL

T_MUX_SCAN_CTRL -- requirements
Module: t_mux_scan_ctrl

---
 rtl/t_mux_pkg.sv | 16 +
 rtl/t_dwell_timer.sv | 32 +++
 rtl/t_mux_scan_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/t_mux_pkg.sv
// Shared constants and FSM state encoding for the mux scan controller.
package t_mux_pkg;

    localparam int NUM_SRC = 13;
    localparam int SEL_W   = 4;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_SETTLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DWELL  = 3'd4
    } state_t;

endpackage

// File: rtl/t_dwell_timer.sv
// Dwell countdown: loaded with the dwell length, decremented while enabled,
// and flags expiry during the last counted cycle.
module t_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    input  logic               i_en,
    input  logic               i_clr,
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_cnt;

    // Remaining dwell cycles; clear has priority so an aborted dwell leaves no residue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == DWELL_W'(1));

endmodule

// File: rtl/t_mux_scan_ctrl.sv
// Scan controller for an external 13:1 byte mux: walks the enabled sources,
// captures each byte after a one-cycle settle, hands it out over a
// valid/ready handshake and optionally dwells between bytes.
module t_mux_scan_ctrl #(
    parameter int NUM_SRC = 13,
    parameter int DWELL_W = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         one_shot,
    input  logic [NUM_SRC-1:0]           src_mask,
    input  logic [DWELL_W-1:0]           dwell,
    output logic [t_mux_pkg::SEL_W-1:0]  sel,
    input  logic [t_mux_pkg::DATA_W-1:0] mux_y,
    output logic [t_mux_pkg::DATA_W-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    import t_mux_pkg::*;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);

    state_t              r_state;
    logic [SEL_W-1:0]    r_idx;
    logic [SEL_W-1:0]    r_sel;
    logic [NUM_SRC-1:0]  r_mask;
    logic [DWELL_W-1:0]  r_dwell;
    logic                r_one_shot;
    logic                r_stop_pend;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_xfer;
    logic                w_stop_any;
    logic                w_last;
    logic                w_tmr_load;
    logic                w_tmr_en;
    logic                w_tmr_clr;
    logic                w_expire;

    assign w_xfer     = r_out_valid && out_ready;
    assign w_stop_any = stop || r_stop_pend;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_tmr_load = (r_state == ST_EMIT) && w_xfer && !w_stop_any && (r_dwell != '0);
    assign w_tmr_en   = (r_state == ST_DWELL);
    assign w_tmr_clr  = (r_state == ST_DWELL) && stop;

    t_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (r_dwell),
        .i_en       (w_tmr_en),
        .i_clr      (w_tmr_clr),
        .o_expire   (w_expire)
    );

    // Scan FSM with registered outputs; every index advance shares the same
    // wrap rule (one-shot ends the lap on 12 -> 0, continuous wraps).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_sel       <= '0;
            r_mask      <= '0;
            r_dwell     <= '0;
            r_one_shot  <= 1'b0;
            r_stop_pend <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_stop_pend <= 1'b0;
                    if (start && !stop) begin
                        if (src_mask == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mask     <= src_mask;
                            r_dwell    <= dwell;
                            r_one_shot <= one_shot;
                            r_idx      <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_SEARCH;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_mask[r_idx]) begin
                        r_sel   <= r_idx;
                        r_state <= ST_SETTLE;
                    end else if (w_last && r_one_shot) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= w_last ? '0 : r_idx + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_out_data  <= mux_y;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_stop_pend <= 1'b0;
                        if (w_stop_any) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (r_dwell != '0) begin
                            r_state <= ST_DWELL;
                        end else if (w_last && r_one_shot) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= w_last ? '0 : r_idx + 1'b1;
                            r_state <= ST_SEARCH;
                        end
                    end
                end
                ST_DWELL: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_expire) begin
                        if (w_last && r_one_shot) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= w_last ? '0 : r_idx + 1'b1;
                            r_state <= ST_SEARCH;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
